// File: rtl/patdet_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding
// and the legal range of the pattern length.
package patdet_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones; clr has priority over inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with optional overlap and a saturating match counter.
// Define PATDET_COUNT_EN to build the counter; otherwise match_count reads 0.
module pattern_detector
    import patdet_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    localparam int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              load,
    input  logic [PAT_W-1:0]  pattern,
    input  logic              en,
    input  logic              w,
    input  logic              overlap,
    output logic              z,
    output logic [FILL_W-1:0] fill,
    output logic [CNT_W-1:0]  match_count,
    output logic              armed
);

    localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W);

    state_e              state_q, state_d;
    logic [PAT_W-1:0]    pat_q,   pat_d;
    logic [PAT_W-1:0]    hist_q,  hist_d;
    logic [FILL_W-1:0]   fill_q,  fill_d;
    logic                z_q,     z_d;

    logic [PAT_W-1:0]    hist_sh;
    logic [FILL_W-1:0]   fill_inc;
    logic                match;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            z_q     <= z_d;
        end
    end

    // A match is judged on the history as it will be after this edge's shift.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        z_d      = 1'b0;
        match    = 1'b0;
        hist_sh  = {hist_q[PAT_W-2:0], w};
        fill_inc = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);

        if (load) begin
            pat_d   = pattern;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if ((state_q != IDLE) && en) begin
            match  = (fill_inc == FULL) && (hist_sh == pat_q);
            z_d    = match;
            hist_d = hist_sh;
            if (match && !overlap) begin
                fill_d  = '0;
                state_d = FILL;
            end else begin
                fill_d  = fill_inc;
                state_d = (fill_inc == FULL) ? ARMED : FILL;
            end
        end
    end

    always_comb begin
        z     = z_q;
        fill  = fill_q;
        armed = (state_q != IDLE);
    end

`ifdef PATDET_COUNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk_i  (Clock),
        .rst_ni (Resetn),
        .inc    (match),
        .clr    (load),
        .q      (match_count)
    );
`else
    assign match_count = '0;
`endif

endmodule
